zl_uart_host: RTL and testbench

Initiator for the single-wire-per-direction register-access protocol used by our UART register slave. Accepts read/write commands on a valid/ready port, serialises an address frame and, for writes, a data frame on `tx`. For reads it captures the returned frame on `rx` and reports data or timeout on a one-cycle response strobe. Runs from the same `clk` as the slave at one bit per clock; no oversampling.

---
 rtl/zl_uart_host.sv | 233 +++++++++++++++++++++++
 tb/tb_zl_uart_host.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zl_uart_host.sv
// ---------------------------------------------------------------------------
// zl_uart_host
//
// Initiator for the single-wire-per-direction register-access protocol.
// A command accepted on the valid/ready port is sent on `tx` as an address
// frame ({addr, write}) and, for writes, a data frame. For reads, the reply
// frame is captured from `rx`. Every transaction ends with a one-cycle
// `rsp_valid` strobe. Frames are a start bit (0) followed by 8 data bits,
// MSB first, at one bit per clock. There is no stop bit.
//
// Parameters
//   GAP      idle-high cycles between frames and after the last frame (1..15)
//   TIMEOUT  cycles to wait for the read-response start bit (1..255)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   cmd_valid    command request
//   cmd_ready    high only in IDLE (and not in reset)
//   cmd_write    1 = write, 0 = read
//   cmd_addr     7-bit register address
//   cmd_wdata    write data
//   rsp_valid    one-cycle strobe at transaction end
//   rsp_write    echo of the command's write bit
//   rsp_timeout  read saw no start bit within TIMEOUT cycles
//   rsp_rdata    read data (0x00 on write or timeout), held until next response
//   tx           serial out, idle high, registered
//   rx           serial in, asynchronous, idle high
// ---------------------------------------------------------------------------
module zl_uart_host #(
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic       rsp_timeout,
  output logic [7:0] rsp_rdata,
  output logic       tx,
  input  logic       rx
);

  localparam logic [7:0] GAP_CNT     = 8'(GAP);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_ADDR,
    S_GAP1,
    S_TX_DATA,
    S_RX_WAIT,
    S_RX_DATA,
    S_GAP2,
    S_RESP
  } state_t;

  state_t      state, state_d;
  logic [3:0]  bit_cnt, bit_cnt_d;    // frame bit index
  logic [7:0]  cnt, cnt_d;            // gap / response-wait counter
  logic [8:0]  tx_sh, tx_sh_d;        // outgoing frame, MSB drives tx
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  data_q, data_d;        // read data being assembled
  logic        rsp_write_d, rsp_timeout_d;
  logic [7:0]  rsp_rdata_d;
  logic        rx_meta, rxs;

  // The frame shifts out of the top bit and ones shift in behind it, so the
  // line returns high by itself once a frame has been sent.
  assign tx        = tx_sh[8];
  assign cmd_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);

  // Both synchroniser flops reset to 1 so the idle line never looks like a
  // start bit right after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      cnt         <= '0;
      tx_sh       <= '1;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      timeout_q   <= 1'b0;
      data_q      <= '0;
      rsp_write   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      cnt         <= cnt_d;
      tx_sh       <= tx_sh_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      timeout_q   <= timeout_d;
      data_q      <= data_d;
      rsp_write   <= rsp_write_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_rdata   <= rsp_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every next-value holds its current value by default, so no path
    // through the case below can infer a latch.
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    cnt_d         = cnt;
    tx_sh_d       = tx_sh;
    wdata_d       = wdata_q;
    write_d       = write_q;
    timeout_d     = timeout_q;
    data_d        = data_q;
    rsp_write_d   = rsp_write;
    rsp_timeout_d = rsp_timeout;
    rsp_rdata_d   = rsp_rdata;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_TX_ADDR;
          write_d   = cmd_write;
          wdata_d   = cmd_wdata;
          timeout_d = 1'b0;
          data_d    = '0;
          bit_cnt_d = '0;
          tx_sh_d   = {1'b0, cmd_addr, cmd_write};
        end
      end

      S_TX_ADDR: begin
        tx_sh_d = {tx_sh[7:0], 1'b1};
        if (bit_cnt == 4'd8) begin
          if (write_q) begin
            state_d = S_GAP1;
            cnt_d   = GAP_CNT;
          end else begin
            state_d = S_RX_WAIT;
            cnt_d   = TIMEOUT_CNT;
          end
        end else begin
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end

      S_GAP1: begin
        if (cnt == 8'd1) begin
          state_d   = S_TX_DATA;
          bit_cnt_d = '0;
          tx_sh_d   = {1'b0, wdata_q};
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      S_TX_DATA: begin
        tx_sh_d = {tx_sh[7:0], 1'b1};
        if (bit_cnt == 4'd8) begin
          state_d = S_GAP2;
          cnt_d   = GAP_CNT;
        end else begin
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end

      // A start bit seen on the final count still wins over the timeout.
      S_RX_WAIT: begin
        if (!rxs) begin
          state_d   = S_RX_DATA;
          bit_cnt_d = '0;
        end else if (cnt == 8'd1) begin
          state_d   = S_GAP2;
          timeout_d = 1'b1;
          cnt_d     = GAP_CNT;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      S_RX_DATA: begin
        data_d = {data_q[6:0], rxs};
        if (bit_cnt == 4'd7) begin
          state_d = S_GAP2;
          cnt_d   = GAP_CNT;
        end else begin
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end

      // Response fields are loaded on the way into RESP so they are valid
      // in the same cycle as the strobe, then held until the next response.
      S_GAP2: begin
        if (cnt == 8'd1) begin
          state_d       = S_RESP;
          rsp_write_d   = write_q;
          rsp_timeout_d = timeout_q;
          rsp_rdata_d   = (write_q || timeout_q) ? 8'h00 : data_q;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_zl_uart_host.sv
// ---------------------------------------------------------------------------
// tb_zl_uart_host
//
// Two hosts share clk/reset: u_dut0 (GAP=2, TIMEOUT=64) carries the write,
// read, stray-pulse, reset and back-to-back cases, with its tx line checked
// bit by bit; u_dut1 (GAP=2, TIMEOUT=4) carries the timeout cases.
// Cycle numbering: `cyc` increments on every rising edge. `h` is the cycle
// right after the handshake edge, which is the cycle carrying the start bit.
// ---------------------------------------------------------------------------
module tb_zl_uart_host;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v0, rdy0, w0, rv0, rw0, rt0, tx0, rx0;
  logic [6:0] a0;
  logic [7:0] d0, rd0;
  logic       v1, rdy1, w1, rv1, rw1, rt1, tx1, rx1;
  logic [6:0] a1;
  logic [7:0] d1, rd1;

  zl_uart_host #(.GAP(GAP), .TIMEOUT(64)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(v0), .cmd_ready(rdy0), .cmd_write(w0), .cmd_addr(a0), .cmd_wdata(d0),
    .rsp_valid(rv0), .rsp_write(rw0), .rsp_timeout(rt0), .rsp_rdata(rd0),
    .tx(tx0), .rx(rx0)
  );

  zl_uart_host #(.GAP(GAP), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(v1), .cmd_ready(rdy1), .cmd_write(w1), .cmd_addr(a1), .cmd_wdata(d1),
    .rsp_valid(rv1), .rsp_write(rw1), .rsp_timeout(rt1), .rsp_rdata(rd1),
    .tx(tx1), .rx(rx1)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          cyc;
    logic        wr;
    logic        to;
    logic [7:0]  rd;
  } rsp_t;

  typedef struct {
    int   cyc;
    logic b;
  } txe_t;

  rsp_t rq0[$];
  rsp_t rq1[$];
  txe_t txq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard pushes ----------------
  task automatic push_bit(input int c, input logic b);
    txe_t e;
    e.cyc = c;
    e.b   = b;
    txq.push_back(e);
  endtask

  task automatic push_frame(input int c, input logic [7:0] b);
    push_bit(c, 1'b0);
    for (int k = 0; k < 8; k++) push_bit(c + 1 + k, b[7-k]);
  endtask

  task automatic push_ones(input int c, input int n);
    for (int k = 0; k < n; k++) push_bit(c + k, 1'b1);
  endtask

  task automatic push_rsp(input int i, input int c, input logic wr, input logic to,
                          input logic [7:0] rd);
    rsp_t r;
    r.cyc = c;
    r.wr  = wr;
    r.to  = to;
    r.rd  = rd;
    if (i == 0) rq0.push_back(r);
    else        rq1.push_back(r);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    txe_t e;
    rsp_t r;
    if (txq.size() > 0 && txq[0].cyc == cyc) begin
      e = txq.pop_front();
      check("tx0_bit", {31'd0, tx0}, {31'd0, e.b});
    end
    if (rv0) begin
      if (rq0.size() == 0) flag_fail("rsp0_unexpected");
      else begin
        r = rq0.pop_front();
        check("rsp0_cycle",   cyc,             r.cyc);
        check("rsp0_write",   {31'd0, rw0},    {31'd0, r.wr});
        check("rsp0_timeout", {31'd0, rt0},    {31'd0, r.to});
        check("rsp0_rdata",   {24'd0, rd0},    {24'd0, r.rd});
      end
    end
    if (rv1) begin
      if (rq1.size() == 0) flag_fail("rsp1_unexpected");
      else begin
        r = rq1.pop_front();
        check("rsp1_cycle",   cyc,             r.cyc);
        check("rsp1_write",   {31'd0, rw1},    {31'd0, r.wr});
        check("rsp1_timeout", {31'd0, rt1},    {31'd0, r.to});
        check("rsp1_rdata",   {24'd0, rd1},    {24'd0, r.rd});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance to cycle c, 1 ns after its opening edge.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command and wait (bounded) for the handshake. Returns the
  // cycle after the handshake edge in h and the number of not-ready cycles
  // seen in waited. Leaves cmd_valid high when hold is set.
  task automatic send(input int i, input logic wr, input logic [6:0] a, input logic [7:0] d,
                      input bit hold, output int h, output int waited);
    logic rdy;
    h = -1;
    waited = 0;
    if (i == 0) begin v0 = 1'b1; w0 = wr; a0 = a; d0 = d; end
    else        begin v1 = 1'b1; w1 = wr; a1 = a; d1 = d; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = (i == 0) ? rdy0 : rdy1;
      if (rdy) begin
        h = cyc + 1;
        break;
      end
      waited++;
    end
    @(posedge clk);
    #1;
    if (h < 0) flag_fail("handshake_timeout");
    if (!hold || h < 0) begin
      if (i == 0) v0 = 1'b0;
      else        v1 = 1'b0;
    end
  endtask

  // Bench responder: start bit on the pin in cycle c, then b MSB first.
  task automatic drive_rx(input int i, input int c, input logic [7:0] b);
    goto(c);
    if (i == 0) rx0 = 1'b0; else rx1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      goto(c + 1 + k);
      if (i == 0) rx0 = b[7-k]; else rx1 = b[7-k];
    end
    goto(c + 9);
    if (i == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic push_write0(input int h, input logic [7:0] abyte, input logic [7:0] d);
    push_frame(h, abyte);
    push_ones(h + 9, GAP);
    push_frame(h + 11, d);
    push_ones(h + 20, GAP);
    push_rsp(0, h + 22, 1'b1, 1'b0, 8'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int h, h2, wt, c0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; rx0 = 1'b1;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; rx1 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_tx",          {31'd0, tx0},  32'd1);
    check("reset_cmd_ready",   {31'd0, rdy0}, 32'd0);
    check("reset_cmd_ready1",  {31'd0, rdy1}, 32'd0);
    check("reset_rsp_valid",   {31'd0, rv0},  32'd0);
    check("reset_rsp_write",   {31'd0, rw0},  32'd0);
    check("reset_rsp_timeout", {31'd0, rt0},  32'd0);
    check("reset_rsp_rdata",   {24'd0, rd0},  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready",  {31'd0, rdy0}, 32'd1);
    check("post_reset_ready1", {31'd0, rdy1}, 32'd1);
    check("post_reset_tx",     {31'd0, tx0},  32'd1);
    @(posedge clk);
    #1;

    // 1: write 0x03 <- 0x55; address byte 0x07.
    send(0, 1'b1, 7'h03, 8'h55, 1'b0, h, wt);
    check("t1_no_wait", wt, 0);
    push_write0(h, 8'h07, 8'h55);
    goto(h + 23);
    @(negedge clk);
    check("t1_ready_back", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1;

    // 2: read 0x00; responder start five cycles after the address frame.
    send(0, 1'b0, 7'h00, 8'h00, 1'b0, h, wt);
    push_frame(h, 8'h00);
    push_ones(h + 9, 17);
    push_rsp(0, h + 26, 1'b0, 1'b0, 8'hDE);
    drive_rx(0, h + 13, 8'hDE);
    goto(h + 30);
    @(negedge clk);
    check("t2_rdata_held", {24'd0, rd0}, 32'h0000_00DE);
    @(posedge clk);
    #1;

    // 3: TIMEOUT=4 read, rx idle apart from a stray pulse during TX_ADDR.
    send(1, 1'b0, 7'h12, 8'h00, 1'b0, h, wt);
    push_rsp(1, h + 15, 1'b0, 1'b1, 8'h00);
    goto(h + 1);
    rx1 = 1'b0;
    goto(h + 4);
    rx1 = 1'b1;
    goto(h + 17);

    // 4: TIMEOUT=4 read, start reaches rxs on the last wait cycle.
    send(1, 1'b0, 7'h34, 8'h00, 1'b0, h, wt);
    push_rsp(1, h + 23, 1'b0, 1'b0, 8'hA5);
    drive_rx(1, h + 10, 8'hA5);
    goto(h + 26);

    // 5: stray rx lows in IDLE and TX_ADDR; write 0x5A <- 0x3C (addr byte 0xB5).
    c0 = cyc;
    rx0 = 1'b0;
    goto(c0 + 3);
    rx0 = 1'b1;
    goto(c0 + 5);
    @(negedge clk);
    check("t5_idle_ready", {31'd0, rdy0}, 32'd1);
    check("t5_idle_tx",    {31'd0, tx0},  32'd1);
    @(posedge clk);
    #1;
    send(0, 1'b1, 7'h5A, 8'h3C, 1'b0, h, wt);
    push_write0(h, 8'hB5, 8'h3C);
    goto(h + 2);
    rx0 = 1'b0;
    goto(h + 5);
    rx0 = 1'b1;
    goto(h + 24);

    // 6: reset in the third TX_DATA cycle of write 0x21 <- 0xC3 (addr 0x43).
    send(0, 1'b1, 7'h21, 8'hC3, 1'b0, h, wt);
    push_frame(h, 8'h43);
    push_ones(h + 9, GAP);
    push_bit(h + 11, 1'b0);
    push_bit(h + 12, 1'b1);
    push_bit(h + 13, 1'b1);
    push_ones(h + 14, 2);
    goto(h + 13);
    reset = 1'b1;
    goto(h + 14);
    @(negedge clk);
    check("t6_ready_in_reset", {31'd0, rdy0}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1;
    goto(h + 30);
    send(0, 1'b1, 7'h7F, 8'h81, 1'b0, h, wt);
    push_write0(h, 8'hFF, 8'h81);
    goto(h + 24);

    // 7: cmd_valid held across two writes.
    send(0, 1'b1, 7'h11, 8'hF0, 1'b1, h, wt);
    push_write0(h, 8'h23, 8'hF0);
    push_ones(h + 22, 2);
    send(0, 1'b1, 7'h22, 8'h0F, 1'b0, h2, wt);
    check("t7_not_ready_cycles", wt, 23);
    check("t7_second_handshake", h2, h + 24);
    push_write0(h2, 8'h45, 8'h0F);
    goto(h2 + 25);

    check("txq_drained", txq.size(), 0);
    check("rq0_drained", rq0.size(), 0);
    check("rq1_drained", rq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
